data_path: RTL and testbench

DATA_PATH -- requirements
Module: data_path

---
 rtl/data_path.sv | 116 +++++++++++
 tb/tb_data_path.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_path.sv
// data_path: single-cycle MIPS32-subset processor.
// Every instruction is fetched, decoded, executed, accesses memory and
// writes back within one clk cycle. imem, dmem and regs are plain arrays
// loaded and inspected hierarchically; there are no load ports.
// Ports:
//   clk      - clock, all state updates on the rising edge
//   clr_PC_n - asynchronous active-low reset (pc, halted, regs)
//   pc       - current program counter (word address)
//   ir       - instruction at imem[pc]
//   halted   - high once HLT has executed; state frozen until reset
// Memory depths are expected to be powers of two: addresses and the pc are
// the low log2(DEPTH) bits of their computed values.
module data_path #(
    parameter int IMEM_DEPTH = 1024,
    parameter int DMEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        clr_PC_n,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic        halted
);
    localparam int IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    logic [31:0] imem [0:IMEM_DEPTH-1];
    logic [31:0] dmem [0:DMEM_DEPTH-1];
    logic [31:0] regs [0:31];

    logic [IAW-1:0] pc_q, pc_d, pc_inc;
    logic           halted_q, halted_d;

    logic [5:0]     opcode;
    logic [4:0]     rs, rt, rd;
    logic [31:0]    imm_s, rs_v, rt_v;
    logic           rf_we, dm_we;
    logic [4:0]     rf_wa;
    logic [31:0]    rf_wd;
    logic [DAW-1:0] dm_a;

    assign ir     = imem[pc_q];
    assign pc     = 32'(pc_q);
    assign halted = halted_q;

    assign opcode = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign imm_s  = {{16{ir[15]}}, ir[15:0]};

    // Read ports see the stored value, so a same-cycle write is not forwarded.
    assign rs_v   = regs[rs];
    assign rt_v   = regs[rt];

    always_comb begin
        pc_inc   = pc_q + 1'b1;
        pc_d     = pc_inc;
        halted_d = 1'b0;
        rf_we    = 1'b0;
        rf_wa    = rd;
        rf_wd    = '0;
        dm_we    = 1'b0;
        dm_a     = DAW'(rs_v + imm_s);
        case (opcode)
            OP_ADD:   begin rf_we = 1'b1; rf_wd = rs_v + rt_v; end
            OP_SUB:   begin rf_we = 1'b1; rf_wd = rs_v - rt_v; end
            OP_AND:   begin rf_we = 1'b1; rf_wd = rs_v & rt_v; end
            OP_OR:    begin rf_we = 1'b1; rf_wd = rs_v | rt_v; end
            OP_SLT:   begin rf_we = 1'b1; rf_wd = {31'b0, $signed(rs_v) < $signed(rt_v)}; end
            // Low 32 bits of a product are identical for signed and unsigned operands.
            OP_MUL:   begin rf_we = 1'b1; rf_wd = rs_v * rt_v; end
            OP_ADDI:  begin rf_we = 1'b1; rf_wa = rt; rf_wd = rs_v + imm_s; end
            OP_SUBI:  begin rf_we = 1'b1; rf_wa = rt; rf_wd = rs_v - imm_s; end
            OP_SLTI:  begin rf_we = 1'b1; rf_wa = rt; rf_wd = {31'b0, $signed(rs_v) < $signed(imm_s)}; end
            OP_LW:    begin rf_we = 1'b1; rf_wa = rt; rf_wd = dmem[dm_a]; end
            OP_SW:    dm_we = 1'b1;
            OP_BNEQZ: if (rs_v != '0) pc_d = IAW'(32'(pc_q) + 32'd1 + imm_s);
            OP_BEQZ:  if (rs_v == '0) pc_d = IAW'(32'(pc_q) + 32'd1 + imm_s);
            // HLT holds the pc on itself so the halted machine shows the HLT address.
            OP_HLT:   begin pc_d = pc_q; halted_d = 1'b1; end
            default:  ; // unknown or X opcode: NOP
        endcase
    end

    always_ff @(posedge clk or negedge clr_PC_n) begin
        if (!clr_PC_n) begin
            pc_q     <= '0;
            halted_q <= 1'b0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (!halted_q) begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
            if (rf_we && rf_wa != 5'd0) regs[rf_wa] <= rf_wd;
        end
    end

    // dmem is not reset; a store is dropped if reset is held across the edge.
    always_ff @(posedge clk) begin
        if (clr_PC_n && !halted_q && dm_we) dmem[dm_a] <= rt_v;
    end
endmodule

// File: tb/tb_data_path.sv
module tb_data_path;
    localparam int IMEM = 1024;
    localparam int DMEM = 1024;

    logic        clk = 1'b0;
    logic        clr_PC_n = 1'b0;
    logic [31:0] pc, ir;
    logic        halted;

    int ncmp = 0;
    int nfail = 0;

    data_path #(.IMEM_DEPTH(IMEM), .DMEM_DEPTH(DMEM)) dut (
        .clk(clk), .clr_PC_n(clr_PC_n), .pc(pc), .ir(ir), .halted(halted)
    );

    always #5 clk = ~clk;

    // Behavioural instruction-set model
    logic [31:0] tb_imem [IMEM];
    logic [31:0] m_regs  [32];
    logic [31:0] m_dmem  [DMEM];
    int          m_pc;
    bit          m_halt;
    logic [31:0] prog [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input int op, input int s, input int t, input int imm);
        enc = {op[5:0], s[4:0], t[4:0], imm[15:0]};
    endfunction

    function automatic logic [31:0] encr(input int op, input int s, input int t, input int d);
        encr = {op[5:0], s[4:0], t[4:0], d[4:0], 11'b0};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_pc = 0;
        m_halt = 0;
    endtask

    task automatic m_step();
        logic [31:0] w, a, b, imm, res;
        longint      p;
        int          dst, t;
        bit          wr;
        if (m_halt) return;
        w   = tb_imem[m_pc];
        a   = m_regs[w[25:21]];
        b   = m_regs[w[20:16]];
        imm = {{16{w[15]}}, w[15:0]};
        dst = int'(w[20:16]);
        wr  = 0;
        res = '0;
        t   = m_pc + 1;
        case (w[31:26])
            6'b000000: begin res = a + b; dst = int'(w[15:11]); wr = 1; end
            6'b000001: begin res = a - b; dst = int'(w[15:11]); wr = 1; end
            6'b000010: begin res = a & b; dst = int'(w[15:11]); wr = 1; end
            6'b000011: begin res = a | b; dst = int'(w[15:11]); wr = 1; end
            6'b000100: begin res = ($signed(a) < $signed(b)) ? 1 : 0; dst = int'(w[15:11]); wr = 1; end
            6'b000101: begin
                p = longint'($signed(a)) * longint'($signed(b));
                res = p[31:0]; dst = int'(w[15:11]); wr = 1;
            end
            6'b001010: begin res = a + imm; wr = 1; end
            6'b001011: begin res = a - imm; wr = 1; end
            6'b001100: begin res = ($signed(a) < $signed(imm)) ? 1 : 0; wr = 1; end
            6'b001000: begin res = m_dmem[(a + imm) % DMEM]; wr = 1; end
            6'b001001: m_dmem[(a + imm) % DMEM] = b;
            6'b001101: if (a != 0) t = m_pc + 1 + $signed(imm);
            6'b001110: if (a == 0) t = m_pc + 1 + $signed(imm);
            6'b111111: begin m_halt = 1; t = m_pc; end
            default: ;
        endcase
        m_pc = ((t % IMEM) + IMEM) % IMEM;
        if (wr && dst != 0) m_regs[dst] = res;
    endtask

    task automatic load();
        for (int i = 0; i < IMEM; i++) begin
            tb_imem[i]  = (i < prog.size()) ? prog[i] : 32'h0;
            dut.imem[i] = tb_imem[i];
        end
    endtask

    function automatic int reg_diff();
        reg_diff = 0;
        for (int i = 0; i < 32; i++) if (dut.regs[i] !== m_regs[i]) reg_diff++;
    endfunction

    function automatic int dmem_diff();
        dmem_diff = 0;
        for (int i = 0; i < DMEM; i++) if (dut.dmem[i] !== m_dmem[i]) dmem_diff++;
    endfunction

    // One clock edge on DUT and model; compare at the falling edge.
    task automatic tick(input bit cmp);
        @(posedge clk);
        m_step();
        @(negedge clk);
        if (cmp) begin
            chk("pc_track", pc, m_pc);
            chk("halt_track", {31'b0, halted}, {31'b0, m_halt});
        end
    endtask

    // Reset held across one rising edge, released at a falling edge.
    task automatic restart();
        @(negedge clk);
        clr_PC_n = 1'b0;
        m_reset();
        @(negedge clk);
        clr_PC_n = 1'b1;
    endtask

    task automatic run_fact(input string tag);
        for (int i = 0; i < 18; i++) tick(1);
        chk({tag, "_not_halted_18"}, {31'b0, halted}, 32'd0);
        tick(1);
        chk({tag, "_halted_19"}, {31'b0, halted}, 32'd1);
        chk({tag, "_pc"}, pc, 32'd6);
        chk({tag, "_r1"}, dut.regs[1], 32'd0);
        chk({tag, "_r2"}, dut.regs[2], 32'd120);
        chk({tag, "_dmem198"}, dut.dmem[198], 32'd120);
        chk({tag, "_dmem200"}, dut.dmem[200], 32'd5);
    endtask

    initial begin
        for (int i = 0; i < DMEM; i++) begin dut.dmem[i] = '0; m_dmem[i] = '0; end
        m_reset();
        prog = {};
        load();

        // Reset state, asynchronous with no clock edge needed
        #2;
        chk("rst_pc", pc, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_regs", reg_diff(), 32'd0);

        // X word executes as NOP
        prog = {32'hxxxxxxxx};
        load();
        restart();
        tick(1);
        chk("x_pc", pc, 32'd1);
        chk("x_regs", reg_diff(), 32'd0);
        chk("x_dmem", dmem_diff(), 32'd0);

        // Writes to R0 are discarded
        prog = {enc(6'b001010, 0, 0, 7), encr(6'b000000, 0, 0, 3)};
        load();
        restart();
        tick(1); tick(1);
        chk("r0_zero", dut.regs[0], 32'd0);
        chk("r3_zero", dut.regs[3], 32'd0);

        // Signed compares
        prog = {enc(6'b001010, 0, 1, -1), enc(6'b001100, 1, 2, 0), encr(6'b000100, 0, 1, 3)};
        load();
        restart();
        for (int i = 0; i < 3; i++) tick(1);
        chk("slt_r1", dut.regs[1], 32'hffff_ffff);
        chk("slti_r2", dut.regs[2], 32'd1);
        chk("slt_r3", dut.regs[3], 32'd0);

        // Branches on R0
        prog = {enc(6'b001110, 0, 0, 2)};
        load();
        restart();
        tick(1);
        chk("beqz_taken", pc, 32'd3);
        prog = {enc(6'b001101, 0, 0, 2)};
        load();
        restart();
        tick(1);
        chk("bneqz_not_taken", pc, 32'd1);

        // Factorial of 5
        prog = {32'h200100c8, 32'h28020001, 32'h14411000, 32'h2c210001,
                32'h3420fffd, 32'h240200c6, 32'hfc000000};
        load();
        dut.dmem[200] = 32'd5;
        m_dmem[200] = 32'd5;
        restart();
        run_fact("fact");
        for (int i = 0; i < 3; i++) tick(1);
        chk("fact_frozen_pc", pc, 32'd6);
        chk("fact_frozen_r2", dut.regs[2], 32'd120);

        // Reset pulse mid-loop, then a full rerun
        dut.dmem[198] = 32'd0;
        m_dmem[198] = 32'd0;
        restart();
        for (int i = 0; i < 8; i++) tick(1);
        clr_PC_n = 1'b0;
        m_reset();
        #2;
        chk("mid_pc", pc, 32'd0);
        chk("mid_regs", reg_diff(), 32'd0);
        chk("mid_halted", {31'b0, halted}, 32'd0);
        @(negedge clk);
        chk("mid_dmem200", dut.dmem[200], 32'd5);
        chk("mid_dmem", dmem_diff(), 32'd0);
        clr_PC_n = 1'b1;
        run_fact("rerun");

        // Randomized programs against the model
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DMEM; i++) begin
                m_dmem[i] = $urandom;
                dut.dmem[i] = m_dmem[i];
            end
            prog = {};
            for (int i = 1; i < 8; i++) prog.push_back(enc(6'b001010, 0, i, int'($urandom_range(0, 65535))));
            for (int i = 0; i < 48; i++) begin
                int k, s, t, d;
                k = int'($urandom_range(0, 13));
                s = int'($urandom_range(0, 7));
                t = int'($urandom_range(0, 7));
                d = int'($urandom_range(0, 7));
                case (k)
                    0, 1, 2, 3, 4, 5: prog.push_back(encr(k, s, t, d));
                    6:  prog.push_back(enc(6'b001010, s, t, int'($urandom_range(0, 65535))));
                    7:  prog.push_back(enc(6'b001011, s, t, int'($urandom_range(0, 65535))));
                    8:  prog.push_back(enc(6'b001100, s, t, int'($urandom_range(0, 65535))));
                    9:  prog.push_back(enc(6'b001000, s, t, int'($urandom_range(0, 63))));
                    10: prog.push_back(enc(6'b001001, s, t, int'($urandom_range(0, 63))));
                    11: prog.push_back(enc(6'b001101, s, 0, int'($urandom_range(0, 6)) - 3));
                    12: prog.push_back(enc(6'b001110, s, 0, int'($urandom_range(0, 6)) - 3));
                    default: prog.push_back(32'hf000_0000 | 32'($urandom_range(0, 255)));
                endcase
            end
            load();
            restart();
            for (int i = 0; i < 300; i++) tick(1);
            chk("rand_regs", reg_diff(), 32'd0);
            chk("rand_dmem", dmem_diff(), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
